// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit: funct3 codes, FSM
// encoding, access-size decode and store lane formatting.
package lsu_pkg;

    // RV32I funct3 codes for loads/stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int unsigned TimeoutCyclesDefault = 16;

    // Access size encoding.
    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    // Unsigned byte/half codes only exist for loads; every unlisted code is a word.
    function automatic logic [1:0] access_size(input logic is_load, input logic [2:0] funct3);
        logic [1:0] size;
        size = SzWord;
        if (funct3 == F3_B || (is_load && funct3 == F3_BU)) begin
            size = SzByte;
        end else if (funct3 == F3_H || (is_load && funct3 == F3_HU)) begin
            size = SzHalf;
        end
        return size;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SzByte:  ok = 1'b1;
            SzHalf:  ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            SzByte:  strb = 4'b0001 << lo;
            SzHalf:  strb = 4'b0011 << {lo[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the store data across lanes so the strobes alone pick the bytes.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        case (size)
            SzByte:  wd = {4{sd[7:0]}};
            SzHalf:  wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load result formatter: lane select plus sign/zero extension.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend according to the load type; unknown codes return the whole word.
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            F3_W:    data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns load/store controls into a handshaked data
// memory access, stalls the pipeline while it is outstanding, and flags
// misaligned accesses and memory timeouts.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready
);

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        err_q, err_d;

    logic        access;
    logic [1:0]  size;
    logic        aligned;
    logic        timeout_hit;
    logic [31:0] fmt_data;

    assign access  = mem_read | mem_write;
    // A load wins when both controls are set, so size decode follows mem_read.
    assign size    = access_size(mem_read, funct3);
    assign aligned = is_aligned(size, addr[1:0]);

    // cnt_q counts REQ cycles already spent, so this cycle is number cnt_q + 1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

    load_formatter u_load_formatter (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (lo_q),
        .funct3_i  (f3_q),
        .data_o    (fmt_data)
    );

    // Next-state logic: accept, wait for ready or timeout, then release for a cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_load_d  = is_load_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        waddr_d    = waddr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        mem_data_d = mem_data_q;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (access && aligned) begin
                    state_d   = StReq;
                    cnt_d     = 32'd0;
                    is_load_d = mem_read;
                    f3_d      = funct3;
                    lo_d      = addr[1:0];
                    waddr_d   = addr[31:2];
                    wstrb_d   = mem_read ? 4'b0000 : store_strobe(size, addr[1:0]);
                    wdata_d   = store_wdata(size, store_data);
                end
            end
            StReq: begin
                cnt_d = cnt_q + 32'd1;
                if (dmem_ready) begin
                    if (is_load_q) begin
                        mem_data_d = fmt_data;
                    end
                    state_d = StDone;
                end else if (timeout_hit) begin
                    if (is_load_q) begin
                        mem_data_d = 32'd0;
                    end
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 32'd0;
            is_load_q  <= 1'b0;
            f3_q       <= 3'd0;
            lo_q       <= 2'd0;
            waddr_q    <= 30'd0;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            mem_data_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_load_q  <= is_load_d;
            f3_q       <= f3_d;
            lo_q       <= lo_d;
            waddr_q    <= waddr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            mem_data_q <= mem_data_d;
            err_q      <= err_d;
        end
    end

    // Pipeline-facing outputs.
    always_comb begin
        stall      = access & aligned & (state_q != StDone);
        misaligned = (state_q == StIdle) & access & ~aligned;
        bus_error  = err_q;
        mem_data   = mem_data_q;
    end

    // Memory-facing outputs; control lines are only live while requesting.
    always_comb begin
        dmem_req   = (state_q == StReq);
        dmem_we    = dmem_req & ~is_load_q;
        dmem_wstrb = dmem_req ? wstrb_q : 4'b0000;
        dmem_addr  = {waddr_q, 2'b00};
        dmem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] mem_data;
    logic        stall, misaligned, bus_error;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_data   (mem_data),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wstrb (dmem_wstrb),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int unsigned ref_nbytes(input logic rd, input logic [2:0] f3);
        if (f3 == 3'd0 || (rd && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (rd && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic bit ref_aligned(input logic rd, input logic [2:0] f3, input logic [31:0] a);
        return (a % ref_nbytes(rd, f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f3);
        int unsigned n;
        int unsigned off;
        logic [31:0] v;
        n = ref_nbytes(1'b1, f3);
        off = a % 4;
        if (n == 4) return w;
        v = (w >> (8 * off)) & ((32'd1 << (8 * n)) - 32'd1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (32'd1 << (8 * n - 1)))
            v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] ref_strobe(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        int unsigned off;
        logic [3:0] s;
        n = ref_nbytes(1'b0, f3);
        off = a % 4;
        s = 4'b0000;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int unsigned n;
        logic [31:0] wd;
        n = ref_nbytes(1'b0, f3);
        wd = 32'd0;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = 8'((sd >> (8 * (i % n))) & 32'hFF);
        return wd;
    endfunction

    // ---------------- transaction model ----------------
    bit          m_busy, m_finishing, m_err, m_load;
    int unsigned m_waited;
    logic [31:0] m_data, m_addr, m_sd;
    logic [2:0]  m_f3;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_finishing <= 0; m_err <= 0; m_waited <= 0; m_data <= 32'd0;
            m_load <= 0; m_addr <= 32'd0; m_sd <= 32'd0; m_f3 <= 3'd0;
        end else if (m_finishing) begin
            m_finishing <= 0;
            m_err <= 0;
        end else if (m_busy) begin
            m_waited <= m_waited + 1;
            if (dmem_ready) begin
                if (m_load) m_data <= ref_load(dmem_rdata, m_addr, m_f3);
                m_busy <= 0;
                m_finishing <= 1;
            end else if (TO != 0 && m_waited + 1 == TO) begin
                if (m_load) m_data <= 32'd0;
                m_busy <= 0;
                m_finishing <= 1;
                m_err <= 1;
            end
        end else if ((mem_read || mem_write) && ref_aligned(mem_read, funct3, addr)) begin
            m_busy <= 1;
            m_waited <= 0;
            m_load <= mem_read;
            m_addr <= addr;
            m_f3 <= funct3;
            m_sd <= store_data;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            bit acc;
            acc = (mem_read || mem_write);
            chk("stall", {31'd0, stall},
                {31'd0, acc && ref_aligned(mem_read, funct3, addr) && !m_finishing});
            chk("misaligned", {31'd0, misaligned},
                {31'd0, !m_busy && !m_finishing && acc && !ref_aligned(mem_read, funct3, addr)});
            chk("bus_error", {31'd0, bus_error}, {31'd0, m_finishing && m_err});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, m_busy});
            chk("mem_data", mem_data, m_data);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, m_busy && !m_load});
            chk("dmem_wstrb", {28'd0, dmem_wstrb},
                {28'd0, (m_busy && !m_load) ? ref_strobe(m_f3, m_addr) : 4'b0000});
            if (m_busy) begin
                chk("dmem_addr", dmem_addr, m_addr & 32'hFFFF_FFFC);
                if (!m_load) chk("dmem_wdata", dmem_wdata, ref_wdata(m_f3, m_sd));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one MEM-stage op and hold it until the pipeline would advance.
    // ready_at: REQ cycle index (0 = first) at which dmem_ready is raised, -1 never.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rw,
                          input int ready_at,
                          output int stall_cnt, output int err_cnt, output int mis_cnt,
                          output int req_cnt, output logic [31:0] cap_addr,
                          output logic [3:0] cap_strb, output logic [31:0] cap_wdata,
                          output logic cap_we);
        bit ended;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        dmem_rdata = rw; dmem_ready = 1'b0;
        stall_cnt = 0; err_cnt = 0; mis_cnt = 0; req_cnt = 0;
        cap_addr = 32'd0; cap_strb = 4'd0; cap_wdata = 32'd0; cap_we = 1'b0;
        ended = 0;
        for (int c = 0; c < 40; c++) begin
            dmem_ready = (ready_at >= 0 && c == ready_at + 1);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus_error) err_cnt++;
            if (misaligned) mis_cnt++;
            if (dmem_req) begin
                req_cnt++;
                cap_addr = dmem_addr; cap_strb = dmem_wstrb;
                cap_wdata = dmem_wdata; cap_we = dmem_we;
            end
            if (!stall) begin
                ended = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL op_bound: access never released the pipeline within 40 cycles");
        end
        tick();
        mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
    endtask

    int sc, ec, mc, rc;
    logic [31:0] ca, cw;
    logic [3:0] cs;
    logic cwe;

    initial begin
        reset = 1'b1; mem_read = 0; mem_write = 0; funct3 = 3'd0; addr = 32'd0;
        store_data = 32'd0; dmem_rdata = 32'd0; dmem_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        tick();

        // LB sign-extended, ready in first REQ cycle, two stall cycles.
        run_op(1, 0, 3'b000, 32'h103, 32'd0, 32'h80FF_FF12, 0, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("lb_data", mem_data, 32'hFFFF_FF80);
        chk("lb_stall_cycles", sc, 2);
        chk("lb_req_addr", ca, 32'h100);

        run_op(1, 0, 3'b101, 32'h102, 32'd0, 32'h8001_1234, 1, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("lhu_data", mem_data, 32'h0000_8001);
        chk("lhu_stall_cycles", sc, 3);
        run_op(1, 0, 3'b001, 32'h102, 32'd0, 32'h8001_1234, 0, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("lh_data", mem_data, 32'hFFFF_8001);

        // SH lane placement; mem_data untouched by a store.
        run_op(0, 1, 3'b001, 32'h206, 32'hDEAD_BEEF, 32'd0, 2, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("sh_addr", ca, 32'h204);
        chk("sh_wstrb", {28'd0, cs}, 32'hC);
        chk("sh_wdata", cw, 32'hBEEF_BEEF);
        chk("sh_we", {31'd0, cwe}, 32'd1);
        chk("sh_keeps_mem_data", mem_data, 32'hFFFF_8001);

        run_op(0, 1, 3'b000, 32'h101, 32'h1234_56EF, 32'd0, 0, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("sb_wstrb", {28'd0, cs}, 32'h2);
        chk("sb_wdata", cw, 32'hEFEF_EFEF);

        // Store with funct3=100 falls back to a word store.
        run_op(0, 1, 3'b100, 32'h300, 32'hCAFE_F00D, 32'd0, 0, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("sw_other_wstrb", {28'd0, cs}, 32'hF);

        // Misaligned LW: no request, single misaligned cycle, no stall.
        run_op(1, 0, 3'b010, 32'h101, 32'd0, 32'h1111_1111, 0, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("mis_pulses", mc, 1);
        chk("mis_no_req", rc, 0);
        chk("mis_no_stall", sc, 0);
        chk("mis_keeps_data", mem_data, 32'hFFFF_8001);

        // Read and write together: the load wins.
        run_op(1, 1, 3'b010, 32'h500, 32'h5555_5555, 32'h0BAD_F00D, 0, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("rw_prio_we", {31'd0, cwe}, 32'd0);
        chk("rw_prio_wstrb", {28'd0, cs}, 32'd0);
        chk("rw_prio_data", mem_data, 32'h0BAD_F00D);

        // Timeout: TO REQ cycles, one bus_error, load result forced to 0.
        run_op(1, 0, 3'b010, 32'h600, 32'd0, 32'h7777_7777, -1, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("to_req_cycles", rc, TO);
        chk("to_bus_error", ec, 1);
        chk("to_data", mem_data, 32'd0);
        @(negedge clk);
        chk("to_back_idle", {31'd0, dmem_req}, 32'd0);
        tick();

        // Load with non-zero result to make the reset visible.
        run_op(1, 0, 3'b100, 32'h701, 32'd0, 32'h0000_A500, 0, sc, ec, mc, rc, ca, cs, cw, cwe);
        chk("lbu_data", mem_data, 32'h0000_00A5);

        // Reset in the second REQ cycle; a late ready must be ignored.
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; dmem_rdata = 32'h1234_5678;
        tick();
        tick();
        reset = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        chk("rreq_before", {31'd0, dmem_req}, 32'd1);
        tick();
        reset = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        chk("rreq_dropped", {31'd0, dmem_req}, 32'd0);
        chk("rreq_mem_data", mem_data, 32'd0);
        chk("rreq_stall", {31'd0, stall}, 32'd0);
        tick();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_ignored", mem_data, 32'd0);
        chk("late_ready_no_req", {31'd0, dmem_req}, 32'd0);
        tick();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the RV32I core: it turns the EX/MEM load/store controls into a handshaked data-memory access. It produces the aligned, sign/zero-extended `mem_data` word that the writeback stage selects with `mem_to_reg = 2'b01`. The pipeline is stalled while an access is outstanding. Misaligned accesses and memory timeouts are flagged instead of being performed.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: max cycles waiting for `dmem_ready` before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load in MEM stage.
- `mem_write`  in  1  store in MEM stage.
- `funct3`  in  3  access size/sign (RV32I encoding).
- `addr`  in  32  byte address from ALU.
- `store_data`  in  32  rs2 value.
- `mem_data`  out  32  formatted load result, registered.
- `stall`  out  1  hold IF/ID/EX/MEM registers.
- `misaligned`  out  1  one-cycle pulse, alignment fault.
- `bus_error`  out  1  one-cycle pulse, timeout abort.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `dmem_wstrb`  out  4  byte-lane write enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  read word.
- `dmem_ready`  in  1  access completes this cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On `mem_read|mem_write`, check alignment.
  - Aligned: latch op, address, strobes and write data, then go to REQ.
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0): no request; `misaligned` pulses this cycle; `stall` stays 0; remain in IDLE; `mem_data` unchanged.
- `mem_read` has priority when both `mem_read` and `mem_write` are set; the store is dropped.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is treated as a word access.
- REQ:
  - `dmem_req`=1 and latched fields are driven, held stable until `dmem_ready`.
  - Wait counter increments each REQ cycle.
  - On `dmem_ready`: a load registers the formatted `dmem_rdata` into `mem_data`; go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES` first: abort, `mem_data`←0 for loads, go to DONE with `bus_error` pending.
- DONE: `stall`=0 for one cycle so the pipeline advances; `bus_error` pulses here if the access aborted; return to IDLE.
- Store strobes:
  - SB: `4'b0001<<addr[1:0]`, `wdata={4{sd[7:0]}}`.
  - SH: `4'b0011<<{addr[1],1'b0}`, `wdata={2{sd[15:0]}}`.
  - SW: `4'b1111`.
- Load format: select byte `addr[1:0]` or half `addr[1]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Reads drive `dmem_wstrb`=0 and `dmem_we`=0.

## Timing
- `stall` is combinational: `(mem_read|mem_write) & aligned & state!=DONE`.
- Load/store issued in cycle t (IDLE):
  - REQ starts at t+1.
  - If `dmem_ready` is high in REQ cycle t+k, DONE is at t+k+1.
  - `mem_data` is valid from t+k+1 and held until the next completed load.
- Minimum latency is 2 cycles of stall (t, t+1); `dmem_ready` in the first REQ cycle is legal.
- Timeout: abort in the REQ cycle where count = `TIMEOUT_CYCLES`; `bus_error` is high in the following DONE cycle only.
- Reset values: state IDLE, counter 0, `mem_data`=0, and `dmem_req`, `dmem_we`, `dmem_wstrb`, `misaligned`, `bus_error` all 0.
- Reset during REQ: `dmem_req` drops at the reset edge; the outstanding `dmem_ready` is ignored.

## Structure
- `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - state encoding;
  - `TIMEOUT_CYCLES` default.
- Sub-module `load_formatter` (combinational): inputs `rdata`, `addr[1:0]`, `funct3`; output extended word. It is reused by any future cache fill path.

## Test plan
- LB at addr 0x103, `dmem_rdata`=0x80FF_FF12, ready in first REQ cycle -> `mem_data`=0xFFFF_FF80; stall high exactly 2 cycles.
- LHU at addr 0x102, rdata 0x8001_1234 -> `mem_data`=0x0000_8001; LH same -> 0xFFFF_8001.
- SH at 0x206, `store_data`=0xDEAD_BEEF -> `dmem_addr`=0x204, `wstrb`=4'b1100, `wdata`=0xBEEF_BEEF, `we`=1.
- LW at 0x101 -> no `dmem_req`, `misaligned` one-cycle pulse, `stall`=0, `mem_data` unchanged.
- Load, `dmem_ready` held low, `TIMEOUT_CYCLES`=4 -> abort after 4 REQ cycles; `bus_error` one pulse; `mem_data`=0; back to IDLE.
- `reset` asserted in second REQ cycle -> next cycle `dmem_req`=0, state IDLE, all outputs at reset values; a late `dmem_ready` has no effect.
